fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the core front end. It drives the `pause` input of the `pc` register and issues one outstanding instruction-memory request at a time for the current PC. It buffers the returned word for decode under a valid/ready handshake. It also handles control-flow redirects from EX: it lets the PC load the redirect target, discards any in-flight stale fetch, and flushes downstream pipeline registers.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core definitions: instruction-fetch state encoding,
//                the canonical NOP instruction and the imem data width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Instruction-memory data width (one 32-bit instruction per response).
    localparam int IMEM_DW = 32;

    // addi x0, x0, 0
    localparam logic [IMEM_DW-1:0] NOP = 32'h0000_0013;

    // Fetch sequencer state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Issues one outstanding imem
//                request at a time for the current PC, buffers the returned
//                word for decode behind a valid/ready handshake, and handles
//                EX redirects (PC reload, stale-response drop, flush).
//  Ports       :
//      clock, reset              core clock, async active-high reset
//      pc                        current PC from the pc register
//      redirect                  EX redirect pulse (npc holds the target)
//      pc_pause                  hold control for the pc register
//      flush                     squash IF/ID and ID/EX this cycle
//      imem_req/addr/gnt         request channel
//      imem_rvalid/rdata         response channel
//      if_valid/if_pc/if_instr   buffered instruction to decode
//      id_ready                  decode accepts the buffered instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] RESET = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [XLEN-1:0]    pc,
    input  logic               redirect,
    output logic               pc_pause,
    output logic               flush,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [IMEM_DW-1:0] imem_rdata,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [IMEM_DW-1:0] if_instr,
    input  logic               id_ready
);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_addr_q;   // address of the granted, in-flight request
    logic            r_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [IMEM_DW-1:0] r_if_instr;

    logic w_active_redirect;

    // Redirects are meaningless before the first request (the pc register is
    // still coming out of its own reset), so IDLE masks them.
    assign w_active_redirect = redirect && (r_state != ST_IDLE);

    assign flush     = w_active_redirect;
    assign imem_req  = (r_state == ST_REQ);
    assign imem_addr = pc;
    // The PC only moves when the buffered instruction is consumed or when a
    // redirect target must be loaded; every other cycle it is frozen.
    assign pc_pause  = !(((r_state == ST_HOLD) && id_ready) || w_active_redirect);

    assign if_valid  = r_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr_q   <= RESET;
            r_valid    <= 1'b0;
            r_if_pc    <= RESET;
            r_if_instr <= NOP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end

                ST_REQ: begin
                    if (imem_gnt && redirect) begin
                        // Granted request is now for a stale PC.
                        r_state <= ST_DROP;
                    end else if (imem_gnt) begin
                        r_addr_q <= pc;
                        r_state  <= ST_WAIT;
                    end
                    // Ungranted redirect: stay, the pc register reloads and the
                    // request is retargeted next cycle.
                end

                ST_WAIT: begin
                    if (imem_rvalid && redirect) begin
                        // Response arrived together with the redirect: it is
                        // both stale and complete, so no DROP wait is needed.
                        r_state <= ST_REQ;
                    end else if (imem_rvalid) begin
                        r_valid    <= 1'b1;
                        r_if_pc    <= r_addr_q;
                        r_if_instr <= imem_rdata;
                        r_state    <= ST_HOLD;
                    end else if (redirect) begin
                        r_state <= ST_DROP;
                    end
                end

                ST_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                    end
                end

                ST_HOLD: begin
                    if (redirect || id_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a behavioural model
//                of the pc register (sync reset, pause, npc = target or pc+4).
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOPI  = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        pc_pause, flush, imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        id_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    // pc register environment model
    always @(posedge clock) begin
        if (reset)          pc <= RST_PC;
        else if (!pc_pause) pc <= redirect ? target : pc + 32'd4;
    end

    fetch_ctrl #(.XLEN(XLEN), .RESET(RST_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .redirect   (redirect),
        .pc_pause   (pc_pause),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .id_ready   (id_ready)
    );

    typedef struct {
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy, redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pause, e_flush, e_valid;
        logic [31:0] e_ifpc, e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic gnt, rv, input logic [31:0] rdata,
                       input logic rdy, redir, input logic [31:0] tgt,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_pause, e_flush, e_valid,
                       input logic [31:0] e_ifpc, e_instr);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir;
        v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr; v.e_pause = e_pause;
        v.e_flush = e_flush; v.e_valid = e_valid; v.e_ifpc = e_ifpc;
        v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] IA = 32'h0050_0093;
    localparam logic [31:0] IB = 32'h00a0_0113;
    localparam logic [31:0] IC = 32'h1111_1111;
    localparam logic [31:0] ID = 32'h00c0_0193;
    localparam logic [31:0] IE = 32'h0010_0073;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        //   gnt rv rdata rdy rd tgt   | req addr    pause fl  v  ifpc   instr
        // best case
        add(1,0,0,  1,0,0,      0,32'h000, 1,0,0, 32'h000, NOPI); // c0  IDLE
        add(1,0,0,  1,0,0,      1,32'h000, 1,0,0, 32'h000, NOPI); // c1  REQ
        add(0,1,IA, 1,0,0,      0,32'h000, 1,0,0, 32'h000, NOPI); // c2  WAIT
        add(0,0,0,  1,0,0,      0,32'h000, 0,0,1, 32'h000, IA);   // c3  HOLD
        add(1,0,0,  1,0,0,      1,32'h004, 1,0,0, 32'h000, IA);   // c4  REQ
        add(0,1,IB, 1,0,0,      0,32'h004, 1,0,0, 32'h000, IA);   // c5  WAIT
        // id_ready low for 5 cycles in HOLD
        for (int i = 0; i < 5; i++)
            add(0,0,0, 0,0,0,   0,32'h004, 1,0,1, 32'h004, IB);
        add(0,0,0,  1,0,0,      0,32'h004, 0,0,1, 32'h004, IB);   // c11 consume
        add(1,0,0,  1,0,0,      1,32'h008, 1,0,0, 32'h004, IB);   // c12 REQ pc+4
        // redirect in WAIT, stale rvalid 3 cycles later
        add(0,0,0,  1,1,32'h100,0,32'h008, 0,1,0, 32'h004, IB);   // c13
        add(0,0,0,  1,0,0,      0,32'h100, 1,0,0, 32'h004, IB);   // c14 DROP
        add(0,0,0,  1,0,0,      0,32'h100, 1,0,0, 32'h004, IB);   // c15 DROP
        add(0,1,DB, 1,0,0,      0,32'h100, 1,0,0, 32'h004, IB);   // c16 stale
        add(1,0,0,  1,0,0,      1,32'h100, 1,0,0, 32'h004, IB);   // c17 REQ
        // redirect together with rvalid in WAIT
        add(0,1,IC, 1,1,32'h200,0,32'h100, 0,1,0, 32'h004, IB);   // c18
        add(1,0,0,  1,0,0,      1,32'h200, 1,0,0, 32'h004, IB);   // c19 REQ
        add(0,1,ID, 1,0,0,      0,32'h200, 1,0,0, 32'h004, IB);   // c20 WAIT
        // redirect in HOLD with id_ready
        add(0,0,0,  1,1,32'h300,0,32'h200, 0,1,1, 32'h200, ID);   // c21
        // grant withheld 4 cycles, redirect in the 2nd
        add(0,0,0,  1,0,0,      1,32'h300, 1,0,0, 32'h200, ID);   // c22
        add(0,0,0,  1,1,32'h400,1,32'h300, 0,1,0, 32'h200, ID);   // c23
        add(0,0,0,  1,0,0,      1,32'h400, 1,0,0, 32'h200, ID);   // c24
        add(0,0,0,  1,0,0,      1,32'h400, 1,0,0, 32'h200, ID);   // c25
        add(1,0,0,  1,0,0,      1,32'h400, 1,0,0, 32'h200, ID);   // c26 grant
        add(0,1,IE, 1,0,0,      0,32'h400, 1,0,0, 32'h200, ID);   // c27 WAIT
        add(0,0,0,  0,0,0,      0,32'h400, 1,0,1, 32'h400, IE);   // c28 HOLD
        add(0,0,0,  1,0,0,      0,32'h400, 0,0,1, 32'h400, IE);   // c29 consume
        // redirect and grant together in REQ, stale rvalid in DROP entry
        add(1,0,0,  1,1,32'h500,1,32'h404, 0,1,0, 32'h400, IE);   // c30
        add(0,1,DB, 1,0,0,      0,32'h500, 1,0,0, 32'h400, IE);   // c31 DROP
        add(0,0,0,  1,0,0,      1,32'h500, 1,0,0, 32'h400, IE);   // c32 REQ

        // reset phase
        repeat (3) @(negedge clock);
        check("reset_if_valid", {31'b0, if_valid}, 32'h0);
        check("reset_if_instr", if_instr, NOPI);
        check("reset_req",      {31'b0, imem_req}, 32'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            if (k != 0) @(negedge clock);
            imem_gnt    = vecs[k].gnt;
            imem_rvalid = vecs[k].rv;
            imem_rdata  = vecs[k].rdata;
            id_ready    = vecs[k].rdy;
            redirect    = vecs[k].redir;
            target      = vecs[k].tgt;
            #1;
            check($sformatf("v%0d_req",   k), {31'b0, imem_req}, {31'b0, vecs[k].e_req});
            check($sformatf("v%0d_addr",  k), imem_addr,         vecs[k].e_addr);
            check($sformatf("v%0d_pause", k), {31'b0, pc_pause}, {31'b0, vecs[k].e_pause});
            check($sformatf("v%0d_flush", k), {31'b0, flush},    {31'b0, vecs[k].e_flush});
            check($sformatf("v%0d_valid", k), {31'b0, if_valid}, {31'b0, vecs[k].e_valid});
            check($sformatf("v%0d_ifpc",  k), if_pc,             vecs[k].e_ifpc);
            check($sformatf("v%0d_instr", k), if_instr,          vecs[k].e_instr);
        end

        // asynchronous reset mid-operation, away from any clock edge
        @(negedge clock);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_req",   {31'b0, imem_req}, 32'h0);
        check("async_ifpc",  if_pc,    RST_PC);
        check("async_instr", if_instr, NOPI);
        check("async_pause", {31'b0, pc_pause}, 32'h1);
        @(negedge clock);
        reset = 1'b0;
        // redirect in IDLE is ignored
        redirect = 1'b1; target = 32'h600;
        #1;
        check("idle_flush", {31'b0, flush},    32'h0);
        check("idle_pause", {31'b0, pc_pause}, 32'h1);
        check("idle_req",   {31'b0, imem_req}, 32'h0);
        @(negedge clock);
        redirect = 1'b0;
        #1;
        check("post_idle_req",  {31'b0, imem_req}, 32'h1);
        check("post_idle_addr", imem_addr, RST_PC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
